// File: rtl/alu_src_pkg.sv
// Shared types and constants for the ALU operand selector.
// Legacy 4-source map, default width and skid-buffer state encoding.
package alu_src_pkg;

   localparam int W_DEF   = 32;

   localparam int SRC_PC  = 0;
   localparam int SRC_A   = 1;
   localparam int SRC_MDR = 2;
   localparam int SRC_B   = 3;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/alu_operand_sel_if.sv
// Source/select request and operand result bundle for alu_operand_sel.
// master = control unit / ALU side, slave = the selector.
interface alu_operand_sel_if #(
   parameter int W = 32,
   parameter int N = 4
);
   localparam int SELW = $clog2(N);

   logic [N*W-1:0]  src;
   logic [SELW-1:0] sel;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    out_data;
   logic [SELW-1:0] out_sel;
   logic            out_valid;
   logic            out_ready;
   logic            sel_err;

   modport master (
      output src, sel, in_valid, out_ready,
      input  in_ready, out_data, out_sel,
      input  out_valid, sel_err
   );

   modport slave (
      input  src, sel, in_valid, out_ready,
      output in_ready, out_data, out_sel,
      output out_valid, sel_err
   );

endinterface

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer.
// in_ready is registered so no comb path exists from out_ready.
module skid_buf2
   import alu_src_pkg::*;
#(
   parameter int DW = 34
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   buf_state_e    state;
   buf_state_e    state_nx;
   logic [DW-1:0] head;
   logic [DW-1:0] skid;
   logic          push;
   logic          pop;

   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_valid = (state != EMPTY);
   assign out_data  = head;

   // State register; in_ready mirrors "next state is not FULL".
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= state_nx;
         in_ready <= (state_nx != FULL);
      end
   end

   // Occupancy transitions from push/pop.
   always_comb begin
      state_nx = state;
      unique case (state)
         EMPTY: if (push) state_nx = ONE;
         ONE: begin
            if (push && !pop)      state_nx = FULL;
            else if (!push && pop) state_nx = EMPTY;
         end
         FULL: if (pop) state_nx = ONE;
         default: state_nx = EMPTY;
      endcase
   end

   // Entry storage: new data lands in head or skid; skid drains into head.
   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
         skid <= '0;
      end else begin
         unique case (state)
            EMPTY: if (push) head <= in_data;
            ONE: begin
               if (push && pop) head <= in_data;
               else if (push)   skid <= in_data;
            end
            FULL: if (pop) head <= skid;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_operand_sel.sv
// N-way W-bit ALU operand selector registered through a 2-entry skid buffer.
// Optional out-of-range sel check: define ALU_OPERAND_SELCHK_EN.
module alu_operand_sel
   import alu_src_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           reset,
   alu_operand_sel_if.slave bus
);

   localparam int SELW = $clog2(N);

   logic [W-1:0] sel_data;
   logic [W+SELW-1:0] buf_out;

   // Source mux; an index with no matching source yields zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (bus.sel == SELW'(k)) sel_data = bus.src[k*W +: W];
      end
   end

   skid_buf2 #(
      .DW (W + SELW)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({sel_data, bus.sel}),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .out_data  (buf_out),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready)
   );

   assign bus.out_data = buf_out[W+SELW-1:SELW];
   assign bus.out_sel  = buf_out[SELW-1:0];

`ifdef ALU_OPERAND_SELCHK_EN
   localparam logic [SELW:0] N_LIM = (SELW+1)'(N);

   logic accept;
   logic oor;
   logic err_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign oor    = ({1'b0, bus.sel} >= N_LIM);

   // Sticky flag for any accepted out-of-range index.
   always_ff @(posedge clk) begin
      if (reset)              err_q <= 1'b0;
      else if (accept && oor) err_q <= 1'b1;
   end

`ifndef SYNTHESIS
   // Report the offending accept as it happens.
   always @(posedge clk) begin
      if (!reset && accept && oor)
         $error("alu_operand_sel: sel %0d out of range", bus.sel);
   end
`endif

   assign bus.sel_err = err_q;
`else
   assign bus.sel_err = 1'b0;
`endif

endmodule
